// File: rtl/sys_defs.sv
// Shared bus definitions for the processor/memory interface used by the Dcache MSHR.
`default_nettype none

`ifndef MEM_LATENCY
`define MEM_LATENCY 4
`endif

package sys_defs;

   typedef enum logic [1:0] {
      BUS_NONE  = 2'h0,
      BUS_LOAD  = 2'h1,
      BUS_STORE = 2'h2
   } BUS_COMMAND;

   typedef logic [3:0] MEM_TAG_t;

   typedef struct packed {
      logic       valid;
      MEM_TAG_t   tag;
      logic [63:0] data;
   } MEM_INFLIGHT_t;

   localparam int       c_MEM_LATENCY = `MEM_LATENCY;
   localparam MEM_TAG_t c_FIRST_TAG   = 4'd1;

   // Tag 0 means "no transaction", so the counter wraps 15 -> 1.
   function automatic MEM_TAG_t next_tag_f(input MEM_TAG_t tag);
      return (tag == 4'd15) ? c_FIRST_TAG : tag + 4'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_lat_pipe.sv
// Fixed-latency shift register carrying in-flight load results; the last stage is the output register.
`default_nettype none

module mem_lat_pipe
   import sys_defs::*;
#(
   parameter int LATENCY = c_MEM_LATENCY
) (
   input  logic          clock,
   input  logic          reset,
   input  MEM_INFLIGHT_t in_i,
   output MEM_INFLIGHT_t out_o
);

   MEM_INFLIGHT_t stage_q [LATENCY];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= in_i;
         for (int i = 1; i < LATENCY; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign out_o = stage_q[LATENCY-1];

endmodule

`default_nettype wire

// File: rtl/mem_tag_responder.sv
// Tagged memory responder: accepts loads/stores, returns load data LATENCY cycles later.
// Define MEM_BACKPRESSURE_EN to add LFSR-driven pseudo-random request refusal.
`default_nettype none

module mem_tag_responder
   import sys_defs::*;
#(
   parameter int MEM_LINES = 256,
   parameter int LATENCY   = c_MEM_LATENCY
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  proc2mem_command,
   input  logic [63:0] proc2mem_addr,
   input  logic [63:0] proc2mem_data,
   output logic [3:0]  mem2proc_response,
   output logic [63:0] mem2proc_data,
   output logic [3:0]  mem2proc_tag
);

   localparam int IDX_W = $clog2(MEM_LINES);

   MEM_TAG_t      next_tag_q, next_tag_d;
   logic [15:0]   busy_q, busy_d;
   logic [63:0]   mem_q [MEM_LINES];

   logic             w_is_load;
   logic             w_is_store;
   logic             w_bp_refuse;
   logic             w_accept;
   logic [IDX_W-1:0] w_idx;
   logic             w_unused_addr;
   MEM_INFLIGHT_t    w_pipe_in;
   MEM_INFLIGHT_t    w_pipe_out;

   assign w_is_load     = (proc2mem_command == BUS_LOAD);
   assign w_is_store    = (proc2mem_command == BUS_STORE);
   assign w_idx         = proc2mem_addr[3 +: IDX_W];
   assign w_unused_addr = ^{proc2mem_addr[63:3+IDX_W], proc2mem_addr[2:0]};

`ifdef MEM_BACKPRESSURE_EN
   logic [7:0] lfsr_q;

   // x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr_q <= 8'hA5;
      end else begin
         lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
   end

   assign w_bp_refuse = (lfsr_q[1:0] == 2'b00);
`else
   assign w_bp_refuse = 1'b0;
`endif

   assign w_accept = !reset && (w_is_load || w_is_store) &&
                     !busy_q[next_tag_q] && !w_bp_refuse;

   assign mem2proc_response = w_accept ? next_tag_q : 4'd0;

   // Load data is captured at acceptance, so stores from earlier cycles are visible.
   always_comb begin
      w_pipe_in       = '0;
      w_pipe_in.valid = w_accept && w_is_load;
      if (w_accept && w_is_load) begin
         w_pipe_in.tag  = next_tag_q;
         w_pipe_in.data = mem_q[w_idx];
      end
   end

   mem_lat_pipe #(
      .LATENCY (LATENCY)
   ) u_lat_pipe (
      .clock (clock),
      .reset (reset),
      .in_i  (w_pipe_in),
      .out_o (w_pipe_out)
   );

   assign mem2proc_tag  = w_pipe_out.valid ? w_pipe_out.tag  : 4'd0;
   assign mem2proc_data = w_pipe_out.valid ? w_pipe_out.data : 64'd0;

   // A returning tag is released at the end of its return cycle, not bypassed.
   always_comb begin
      next_tag_d = next_tag_q;
      busy_d     = busy_q;
      if (w_pipe_out.valid) begin
         busy_d[w_pipe_out.tag] = 1'b0;
      end
      if (w_accept) begin
         next_tag_d = next_tag_f(next_tag_q);
         if (w_is_load) begin
            busy_d[next_tag_q] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         next_tag_q <= c_FIRST_TAG;
         busy_q     <= '0;
      end else begin
         next_tag_q <= next_tag_d;
         busy_q     <= busy_d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < MEM_LINES; i++) begin
            mem_q[i] <= '0;
         end
      end else if (w_accept && w_is_store) begin
         mem_q[w_idx] <= proc2mem_data;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_tag_responder.sv
// Directed and randomized checks of mem_tag_responder against a transaction-level model.
`default_nettype none

module tb_mem_tag_responder;

   localparam int L     = 4;
   localparam int LINES = 256;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  cmd   = 2'd0;
   logic [63:0] addr  = 64'd0;
   logic [63:0] wdata = 64'd0;
   logic [3:0]  resp;
   logic [3:0]  rtag;
   logic [63:0] rdata;

   mem_tag_responder #(
      .MEM_LINES (LINES),
      .LATENCY   (L)
   ) dut (
      .clock             (clock),
      .reset             (reset),
      .proc2mem_command  (cmd),
      .proc2mem_addr     (addr),
      .proc2mem_data     (wdata),
      .mem2proc_response (resp),
      .mem2proc_data     (rdata),
      .mem2proc_tag      (rtag)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   typedef struct {
      int          due;
      int          tag;
      logic [63:0] data;
   } ret_t;

   logic [63:0] m_mem [LINES];
   int          m_busy_until [16];
   int          m_next_tag;
   int          t;
   logic [7:0]  m_lfsr;
   ret_t        m_q [$];

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, t);
      end
   endtask

   function automatic logic [7:0] lfsr_next(input logic [7:0] x);
      return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
   endfunction

   function automatic bit bp_refuse();
`ifdef MEM_BACKPRESSURE_EN
      return (m_lfsr[1:0] == 2'b00);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_reset();
      for (int i = 0; i < LINES; i++) m_mem[i] = 64'd0;
      for (int i = 0; i < 16; i++) m_busy_until[i] = -1;
      m_q.delete();
      m_next_tag = 1;
      t          = 0;
      m_lfsr     = 8'hA5;
   endtask

   // Reset held for n edges with a LOAD on the bus to show it is refused.
   task automatic do_reset(input int n);
      reset = 1'b1;
      cmd   = 2'd1;
      addr  = 64'h40;
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         #1;
         check("reset_response", 64'(resp), 64'd0);
         check("reset_tag", 64'(rtag), 64'd0);
         check("reset_data", rdata, 64'd0);
      end
      reset = 1'b0;
      cmd   = 2'd0;
      model_reset();
   endtask

   task automatic step(input logic [1:0] c, input logic [63:0] a, input logic [63:0] d,
                       output int got_resp);
      int exp_resp;
      int idx;
      ret_t r;
      cmd   = c;
      addr  = a;
      wdata = d;
      #1;
      exp_resp = 0;
      if ((c == 2'd1 || c == 2'd2) && !bp_refuse() && m_busy_until[m_next_tag] < t)
         exp_resp = m_next_tag;
      got_resp = int'(resp);
      check("response", 64'(resp), 64'(exp_resp));
      idx = int'((a >> 3) % LINES);
      if (exp_resp != 0) begin
         if (c == 2'd1) begin
            m_q.push_back('{t + L, exp_resp, m_mem[idx]});
            m_busy_until[exp_resp] = t + L;
         end else begin
            m_mem[idx] = d;
         end
         m_next_tag = (m_next_tag == 15) ? 1 : m_next_tag + 1;
      end
      @(posedge clock);
      #1;
      t++;
      m_lfsr = lfsr_next(m_lfsr);
      if (m_q.size() > 0 && m_q[0].due == t) begin
         r = m_q.pop_front();
         check("return_tag", 64'(rtag), 64'(r.tag));
         check("return_data", rdata, r.data);
      end else begin
         check("idle_tag", 64'(rtag), 64'd0);
         check("idle_data", rdata, 64'd0);
      end
   endtask

   task automatic idle(input int n);
      int dummy;
      for (int i = 0; i < n; i++) step(2'd0, 64'd0, 64'd0, dummy);
   endtask

   initial begin
      int          r;
      int          first_nz;
      logic [63:0] a;

      model_reset();
      do_reset(3);

      // Store then load of the same word.
      step(2'd2, 64'h40, 64'hDEAD_BEEF, r);
      step(2'd1, 64'h40, 64'd0, r);
      idle(L + 2);

      // Sixteen back-to-back loads across the tag wrap.
      do_reset(1);
      for (int i = 0; i < 16; i++) step(2'd1, 64'(i * 8), 64'd0, r);
      idle(L + 2);

      // Load followed by a store to the same word; a later load sees the store.
      step(2'd1, 64'h48, 64'd0, r);
      step(2'd2, 64'h48, 64'd5, r);
      idle(2);
      step(2'd1, 64'h48, 64'd0, r);
      step(2'd1, 64'hFFFF_0000_0000_0048 | 64'h7, 64'd0, r);
      idle(L + 2);

      // Reset two cycles after a load: the load never returns.
      step(2'd1, 64'h40, 64'd0, r);
      idle(2);
      do_reset(1);
      idle(L + 2);
      step(2'd1, 64'h40, 64'd0, r);
      idle(L + 1);

      // Load held from reset; first accepted tag must be 1.
      do_reset(1);
      first_nz = 0;
      for (int i = 0; i < 40; i++) begin
         step(2'd1, 64'h80, 64'd0, r);
         if (first_nz == 0 && r != 0) first_nz = r;
      end
      check("first_nonzero_response", 64'(first_nz), 64'd1);
      idle(L + 2);

      // Randomized traffic over a small, aliased set of words.
      for (int i = 0; i < 400; i++) begin
         a = {$urandom(), $urandom()};
         a[10:3] = 8'($urandom_range(0, 7));
         step(2'($urandom_range(0, 3)), a, {$urandom(), $urandom()}, r);
      end
      idle(L + 2);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
